// File: rtl/uart_core_param.sv
// uart_core_param: shared baud tick, RX/TX FSMs, single-entry RX holding register, sticky errors.
// Optional parity framing is enabled by defining UART_PARITY_EN (sense set by PARITY_ODD).
module uart_core_param #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_W     = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              tx,
  input  logic [DBIT-1:0]   tx_data,
  input  logic              tx_wr,
  output logic              tx_busy,
  output logic [DBIT-1:0]   rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              parity_err,
  input  logic              err_clr
);

  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  // Baud tick; the divisor is captured at each wrap so a new value never truncates a period.
  logic [DVSR_W-1:0] cnt_q, dvsr_q;
  logic              tick;

  assign tick = (cnt_q == dvsr_q);

  // RX path
  logic              rx_meta_q, rx_sync_q;
  state_e            rx_state_q, rx_state_d;
  logic [S_W-1:0]    rx_s_q, rx_s_d;
  logic [N_W-1:0]    rx_n_q, rx_n_d;
  logic [DBIT-1:0]   rx_b_q, rx_b_d;
  logic [DBIT-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_err_q, overrun_err_d;
  logic              rx_deliver, rx_frame_evt, rx_overrun_evt;
`ifdef UART_PARITY_EN
  logic              parity_err_q, parity_err_d;
  logic              rx_par_evt;
`endif

  // TX path
  state_e            tx_state_q, tx_state_d;
  logic [S_W-1:0]    tx_s_q, tx_s_d;
  logic [N_W-1:0]    tx_n_q, tx_n_d;
  logic [DBIT-1:0]   tx_b_q, tx_b_d;
  logic              tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  // NOTE: every *_d is given its default first, so no branch can leave a latch behind.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_s_d       = rx_s_q;
    rx_n_d       = rx_n_q;
    rx_b_d       = rx_b_q;
    rx_deliver   = 1'b0;
    rx_frame_evt = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_evt   = 1'b0;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = ST_START;
          rx_s_d     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_s_q == S_W'(7)) begin
            if (rx_sync_q) begin
              rx_state_d = ST_IDLE;
            end else begin
              rx_state_d = ST_DATA;
              rx_s_d     = '0;
              rx_n_d     = '0;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_s_q == S_W'(15)) begin
            rx_s_d = '0;
            rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
            if (rx_n_q == N_W'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = ST_PARITY;
`else
              rx_state_d = ST_STOP;
`endif
            end else begin
              rx_n_d = rx_n_q + 1'b1;
            end
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (rx_s_q == S_W'(15)) begin
            rx_s_d     = '0;
            rx_state_d = ST_STOP;
            rx_par_evt = ((^rx_b_q) ^ rx_sync_q) != PAR_ODD;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (rx_s_q == S_W'(SB_TICK - 1)) begin
            rx_state_d   = ST_IDLE;
            rx_deliver   = rx_sync_q;
            rx_frame_evt = !rx_sync_q;
          end else begin
            rx_s_d = rx_s_q + 1'b1;
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Holding register: a read in the same cycle as a delivery frees the slot for the new byte.
  always_comb begin
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q & ~rx_rd;
    rx_overrun_evt = 1'b0;
    if (rx_deliver) begin
      if (rx_valid_q && !rx_rd) begin
        rx_overrun_evt = 1'b1;
      end else begin
        rx_data_d  = rx_b_q;
        rx_valid_d = 1'b1;
      end
    end
    frame_err_d   = (frame_err_q & ~err_clr) | rx_frame_evt;
    overrun_err_d = (overrun_err_q & ~err_clr) | rx_overrun_evt;
`ifdef UART_PARITY_EN
    parity_err_d  = (parity_err_q & ~err_clr) | rx_par_evt;
`endif
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_d       = tx_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (tx_wr) begin
          tx_state_d = ST_START;
          tx_s_d     = '0;
          tx_b_d     = tx_data;
          tx_d       = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = (^tx_data) ^ PAR_ODD;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_s_q == S_W'(15)) begin
            tx_state_d = ST_DATA;
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_d       = tx_b_q[0];
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s_q == S_W'(15)) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == N_W'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_d = ST_PARITY;
              tx_d       = tx_par_q;
`else
              tx_state_d = ST_STOP;
              tx_d       = 1'b1;
`endif
            end else begin
              tx_n_d = tx_n_q + 1'b1;
              tx_d   = tx_b_q[1];
            end
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (tx_s_q == S_W'(15)) begin
            tx_state_d = ST_STOP;
            tx_s_d     = '0;
            tx_d       = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (tx_s_q == S_W'(SB_TICK - 1)) begin
            tx_state_d = ST_IDLE;
            tx_d       = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 1'b1;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      dvsr_q        <= dvsr;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_s_q        <= '0;
      rx_n_q        <= '0;
      rx_b_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      tx_state_q    <= ST_IDLE;
      tx_s_q        <= '0;
      tx_n_q        <= '0;
      tx_b_q        <= '0;
      tx_q          <= 1'b1;
`ifdef UART_PARITY_EN
      parity_err_q  <= 1'b0;
      tx_par_q      <= 1'b0;
`endif
    end else begin
      if (tick) begin
        cnt_q  <= '0;
        dvsr_q <= dvsr;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_state_q    <= rx_state_d;
      rx_s_q        <= rx_s_d;
      rx_n_q        <= rx_n_d;
      rx_b_q        <= rx_b_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      tx_state_q    <= tx_state_d;
      tx_s_q        <= tx_s_d;
      tx_n_q        <= tx_n_d;
      tx_b_q        <= tx_b_d;
      tx_q          <= tx_d;
`ifdef UART_PARITY_EN
      parity_err_q  <= parity_err_d;
      tx_par_q      <= tx_par_d;
`endif
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = (tx_state_q != ST_IDLE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Directed/randomized bench for uart_core_param: waveform model for TX, frame injector for RX,
// loopback with a byte scoreboard, holding-register and sticky-flag scenarios.
module tb_uart_core_param;

  localparam int DBIT       = 8;
  localparam int SB_TICK    = 16;
  localparam int DVSR_W     = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DVSR_W-1:0] dvsr;
  logic              rx, tx, rx_drv, loop_en;
  logic [DBIT-1:0]   tx_data, rx_data;
  logic              tx_wr, tx_busy, rx_valid, rx_rd;
  logic              frame_err, overrun_err, parity_err, err_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx = loop_en ? tx : rx_drv;

  uart_core_param #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_W(DVSR_W), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err),
    .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: parity bit making the total count of ones even (or odd).
  function automatic logic ref_parity(input int d);
    int ones = 0;
    for (int i = 0; i < DBIT; i++) ones += (d >> i) & 1;
    return ((ones + PARITY_ODD) % 2) == 1;
  endfunction

  // Reference: frame bit k (0 = start, then data LSB first, optional parity, then stop).
  function automatic logic ref_bit(input int d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DBIT) return ((d >> (k - 1)) & 1) == 1;
    if (PBITS == 1 && k == DBIT + 1) return ref_parity(d);
    return 1'b1;
  endfunction

  task automatic flags_zero(input string tag);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun_err"}, overrun_err, 0);
    check({tag, "_parity_err"}, parity_err, 0);
  endtask

  task automatic set_dvsr(input int v);
    dvsr = DVSR_W'(v);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_tx_idle_wait"}, n < 20000, 1);
  endtask

  task automatic wait_rx_valid(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_rx_valid_wait"}, n < 20000, 1);
  endtask

  // Record tx every clk while busy, then compare bit centres against the frame model.
  task automatic tx_capture(input int d, input string tag);
    int   dv, p, sl, nb, dlen, l0, idx;
    logic q[$];
    dv = int'(dvsr);
    p  = 16 * (dv + 1);
    sl = SB_TICK * (dv + 1);
    nb = 1 + DBIT + PBITS;
    wait_tx_idle(tag);
    tx_data = DBIT'(d);
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    check({tag, "_start_busy_tx"}, {tx_busy, tx}, 2'b10);
    q.delete();
    while (tx_busy === 1'b1 && q.size() < 20000) begin
      q.push_back(tx);
      @(negedge clk);
    end
    dlen = q.size();
    l0   = dlen - p * (nb - 1) - sl;
    check($sformatf("%s_start_len_%0d", tag, l0), (l0 >= p - dv) && (l0 <= p), 1);
    for (int k = 0; k <= nb; k++) begin
      if (k == 0)      idx = l0 / 2;
      else if (k < nb) idx = l0 + p * (k - 1) + p / 2;
      else             idx = l0 + p * (nb - 1) + sl / 2;
      check($sformatf("%s_bit%0d", tag, k),
            (idx >= 0 && idx < dlen) ? q[idx] : 1'bx, ref_bit(d, k));
    end
    check({tag, "_tx_after_busy"}, tx, 1);
  endtask

  // Drive one frame on rx, aligned to the tick phase. lat = clk count from frame start until
  // rx_valid rises (when it was low at the start); rd_at > 0 places rx_rd on that delivery edge.
  task automatic send_frame(input int d, input logic stop_bit, input logic par_bit,
                            input int rd_at, output int lat);
    int   dv, p, t;
    logic was_valid;
    logic bits[$];
    int   lens[$];
    dv = int'(dvsr);
    p  = 16 * (dv + 1);
    while ((cyc % (dv + 1)) != 0) @(negedge clk);
    bits = {1'b0};
    lens = {p};
    for (int i = 0; i < DBIT; i++) begin
      bits.push_back(((d >> i) & 1) == 1);
      lens.push_back(p);
    end
    if (PBITS == 1) begin
      bits.push_back(par_bit);
      lens.push_back(p);
    end
    bits.push_back(stop_bit);
    lens.push_back(stop_bit ? SB_TICK * (dv + 1) : 3 * p / 4);
    bits.push_back(1'b1);
    lens.push_back(p);
    lat       = -1;
    t         = 0;
    was_valid = rx_valid;
    foreach (bits[b]) begin
      rx_drv = bits[b];
      repeat (lens[b]) begin
        @(negedge clk);
        t++;
        if (lat < 0 && was_valid === 1'b0 && rx_valid === 1'b1) lat = t;
        rx_rd = (rd_at > 0) && (t == rd_at - 1);
      end
    end
    rx_rd = 1'b0;
  endtask

  task automatic loop_byte(input int d, input string tag, input bit poke);
    wait_tx_idle(tag);
    tx_data = DBIT'(d);
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    if (poke) begin
      repeat (100) @(negedge clk);
      tx_data = 8'hEE;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr = 1'b0;
    end
    wait_rx_valid(tag);
    check({tag, "_data"}, rx_data, d);
    read_rx();
    check({tag, "_valid_cleared"}, rx_valid, 0);
  endtask

  initial begin
    int lat, lat2, b;
    int loop_q[$];

    reset   = 1'b1;
    dvsr    = DVSR_W'(3);
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    tx_wr   = 1'b0;
    tx_data = '0;
    rx_rd   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    flags_zero("rst");

    // Reset while a frame is on the wire.
    tx_data = 8'h3C;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (200) @(negedge clk);
    check("midtx_busy", tx_busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_valid", rx_valid, 0);
    flags_zero("midrst");
    repeat (100) @(negedge clk);
    check("midrst_quiet", {tx_busy, tx}, 2'b01);

    // TX waveform: directed byte, then a random byte at a random divisor.
    tx_capture(8'hA5, "txA5");
    set_dvsr($urandom_range(0, 3));
    tx_capture($urandom_range(0, 255), "txrnd");
    set_dvsr(3);
`ifdef UART_PARITY_EN
    tx_capture(8'h07, "tx07par");
`endif

    // Loopback: directed bytes back-to-back, a write while busy, then random bytes.
    loop_en = 1'b1;
    loop_q  = {8'h00, 8'hFF, 8'h5A};
    foreach (loop_q[i]) loop_byte(loop_q[i], $sformatf("loop%0d", i), i == 0);
    set_dvsr($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      b = $urandom_range(0, 255);
      loop_byte(b, $sformatf("looprnd%0d", i), 1'b0);
    end
    flags_zero("loop");
    wait_tx_idle("loopend");
    loop_en = 1'b0;
    set_dvsr(3);

    // Overrun: second byte dropped while the first is unread.
    send_frame(8'h11, 1'b1, ref_parity(8'h11), 0, lat);
    check("ovr1_valid", rx_valid, 1);
    check("ovr1_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, ref_parity(8'h22), 0, lat2);
    check("ovr2_data", rx_data, 8'h11);
    check("ovr2_valid", rx_valid, 1);
    check("ovr2_flag", overrun_err, 1);
    pulse_err_clr();
    check("ovr_clr", overrun_err, 0);
    read_rx();
    check("ovr_read", rx_valid, 0);

    // Read coincident with the second delivery: new byte replaces the old, no overrun.
    send_frame(8'h11, 1'b1, ref_parity(8'h11), 0, lat);
    check("coin_lat_seen", lat > 1, 1);
    send_frame(8'h22, 1'b1, ref_parity(8'h22), lat, lat2);
    check("coin_data", rx_data, 8'h22);
    check("coin_valid", rx_valid, 1);
    check("coin_no_ovr", overrun_err, 0);
    read_rx();

    // Framing error: stop bit sampled low.
    send_frame(8'h81, 1'b0, ref_parity(8'h81), 0, lat);
    check("ferr_flag", frame_err, 1);
    check("ferr_valid", rx_valid, 0);
    pulse_err_clr();
    check("ferr_clr", frame_err, 0);

    // False start: 20 clk low pulse is rejected at the start-bit centre.
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (700) @(negedge clk);
    check("fstart_valid", rx_valid, 0);
    flags_zero("fstart");

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, lat);
    check("perr_flag", parity_err, 1);
    check("perr_data", rx_data, 8'h07);
    check("perr_valid", rx_valid, 1);
    read_rx();
    pulse_err_clr();
    check("perr_clr", parity_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
